// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: coin credit, drink selection, timed dispense and tick-paced refund; VEND_STATS_EN enables the vend counter
module vend_dispense_ctrl #(
    parameter int PRICE1     = 1,
    parameter int PRICE2     = 2,
    parameter int PRICE3     = 3,
    parameter int MAX_CREDIT = 3,
    parameter int CREDIT_W   = 2,
    parameter int DISP_TICKS = 4
) (
    input  logic                clk,
    input  logic                btnC,
    input  logic                tick,
    input  logic                coin_in,
    input  logic [2:0]          sel,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic [2:0]          motor,
    output logic                change_out,
    output logic                coin_reject,
    output logic                sel_err,
    output logic                busy,
    output logic [15:0]         vend_count
);
    localparam int TW = $clog2(DISP_TICKS + 1);
    localparam logic [CREDIT_W:0] MAXC = (CREDIT_W+1)'(MAX_CREDIT);
    typedef enum logic [1:0] {IDLE, DISPENSE, REFUND} state_t;
    state_t state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [CREDIT_W-1:0] credit_n, price;
    logic [CREDIT_W:0] sum;
    logic [2:0] sel_oh, motor_n;
    logic change_n, reject_n, err_n, sel_ok;
    assign sel_oh = sel & (~sel + 3'd1);
    assign price = sel_oh[0] ? CREDIT_W'(PRICE1) : sel_oh[1] ? CREDIT_W'(PRICE2) : CREDIT_W'(PRICE3);
    assign sel_ok = |sel && credit >= price;
    assign sum = {1'b0, credit} - (sel_ok ? {1'b0, price} : '0) + (CREDIT_W+1)'(coin_in);
    // next-state and registered-output values for the sequencer
    always_comb begin
        state_n  = state;
        credit_n = credit;
        timer_n  = timer;
        motor_n  = motor;
        change_n = 1'b0;
        reject_n = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                credit_n = sum > MAXC ? MAXC[CREDIT_W-1:0] : sum[CREDIT_W-1:0];
                reject_n = sum > MAXC;
                err_n    = |sel && !sel_ok;
                if (sel_ok) begin
                    state_n = DISPENSE;
                    timer_n = TW'(DISP_TICKS);
                    motor_n = sel_oh;
                end else if (cancel && credit != '0)
                    state_n = REFUND;
            end
            DISPENSE: begin
                reject_n = coin_in;
                if (tick) begin
                    timer_n = timer - TW'(1);
                    if (timer == TW'(1)) begin
                        motor_n = '0;
                        state_n = credit != '0 ? REFUND : IDLE;
                    end
                end
            end
            REFUND: begin
                reject_n = coin_in;
                if (tick && credit != '0) begin
                    change_n = 1'b1;
                    credit_n = credit - CREDIT_W'(1);
                    state_n  = credit == CREDIT_W'(1) ? IDLE : REFUND;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // state and output registers; btnC overrides everything
    always_ff @(posedge clk) begin
        if (btnC) begin
            state       <= IDLE;
            credit      <= '0;
            timer       <= '0;
            motor       <= '0;
            change_out  <= 1'b0;
            coin_reject <= 1'b0;
            sel_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            timer       <= timer_n;
            motor       <= motor_n;
            change_out  <= change_n;
            coin_reject <= reject_n;
            sel_err     <= err_n;
            busy        <= state_n != IDLE;
        end
    end
`ifdef VEND_STATS_EN
    // count every entry into DISPENSE, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (btnC)
            vend_count <= '0;
        else if (state_n == DISPENSE && state != DISPENSE)
            vend_count <= vend_count + 16'd1;
    end
`else
    assign vend_count = 16'h0000;
`endif
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl: vector table, corner sequences and random stimulus against a credit/drink model
module tb_vend_dispense_ctrl;
`ifdef VEND_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int MAXC = 3;
    localparam int DT = 4;
    typedef struct {
        bit r, t, c;
        bit [2:0] s;
        bit x;
        int cr, mo;
        bit ch, rj, er, bz;
    } vec_t;
    vec_t tv[$];
    logic clk = 1'b0;
    logic btnC = 1'b1, tick = 1'b0, coin_in = 1'b0, cancel = 1'b0;
    logic [2:0] sel = 3'b000;
    logic [1:0] credit;
    logic [2:0] motor;
    logic change_out, coin_reject, sel_err, busy;
    logic [15:0] vend_count;
    int checks = 0, failures = 0;
    int m_credit = 0, m_drink = 0, m_left = 0, m_vends = 0;
    bit m_refund = 0, e_change = 0, e_reject = 0, e_err = 0;

    vend_dispense_ctrl dut (
        .clk(clk), .btnC(btnC), .tick(tick), .coin_in(coin_in), .sel(sel), .cancel(cancel),
        .credit(credit), .motor(motor), .change_out(change_out), .coin_reject(coin_reject),
        .sel_err(sel_err), .busy(busy), .vend_count(vend_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // drive one cycle of inputs, advance the model by the machine's rules, wait past the edge
    task automatic step(input bit r, input bit t, input bit c, input logic [2:0] s, input bit x);
        int d, p, nc;
        bit ok;
        btnC = r; tick = t; coin_in = c; sel = s; cancel = x;
        e_change = 0; e_reject = 0; e_err = 0;
        if (r) begin
            m_credit = 0; m_drink = 0; m_left = 0; m_refund = 0; m_vends = 0;
        end else if (m_drink != 0) begin
            e_reject = c;
            if (t) begin
                m_left--;
                if (m_left == 0) begin
                    m_drink = 0;
                    m_refund = m_credit > 0;
                end
            end
        end else if (m_refund) begin
            e_reject = c;
            if (t) begin
                e_change = 1;
                m_credit--;
                m_refund = m_credit > 0;
            end
        end else begin
            d = s[0] ? 1 : s[1] ? 2 : s[2] ? 3 : 0;
            p = d;
            ok = d != 0 && m_credit >= p;
            e_err = d != 0 && !ok;
            nc = m_credit - (ok ? p : 0) + int'(c);
            if (nc > MAXC) begin
                nc = MAXC;
                e_reject = 1;
            end
            if (ok) begin
                m_drink = d;
                m_left = DT;
                m_vends++;
            end else if (x && m_credit > 0)
                m_refund = 1;
            m_credit = nc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".credit"}, int'(credit), m_credit);
        chk({tag, ".motor"}, int'(motor), m_drink == 0 ? 0 : (1 << (m_drink - 1)));
        chk({tag, ".change_out"}, int'(change_out), int'(e_change));
        chk({tag, ".coin_reject"}, int'(coin_reject), int'(e_reject));
        chk({tag, ".sel_err"}, int'(sel_err), int'(e_err));
        chk({tag, ".busy"}, int'(busy), int'(m_drink != 0 || m_refund));
        chk({tag, ".vend_count"}, int'(vend_count), STATS ? (m_vends % 65536) : 0);
    endtask

    function automatic void add(input bit r, t, c, input bit [2:0] s, input bit x,
                                input int cr, mo, input bit ch, rj, er, bz);
        vec_t v;
        v.r = r; v.t = t; v.c = c; v.s = s; v.x = x;
        v.cr = cr; v.mo = mo; v.ch = ch; v.rj = rj; v.er = er; v.bz = bz;
        tv.push_back(v);
    endfunction

    initial begin
        //   r  t  c  sel     x   cr mo ch rj er bz
        add(1, 0, 0, 3'b000, 0,  0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 3'b000, 0,  1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 3'b000, 0,  2, 0, 0, 0, 0, 0);
        add(0, 0, 0, 3'b010, 0,  0, 2, 0, 0, 0, 1);
        add(0, 1, 0, 3'b000, 0,  0, 2, 0, 0, 0, 1);
        add(0, 0, 0, 3'b000, 0,  0, 2, 0, 0, 0, 1);
        add(0, 1, 0, 3'b000, 0,  0, 2, 0, 0, 0, 1);
        add(0, 1, 0, 3'b000, 0,  0, 2, 0, 0, 0, 1);
        add(0, 1, 0, 3'b000, 0,  0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 3'b000, 0,  1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 3'b100, 0,  1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 3'b000, 0,  1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 3'b000, 1,  1, 0, 0, 0, 0, 1);
        add(0, 1, 0, 3'b000, 0,  0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 3'b000, 0,  1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 3'b000, 0,  2, 0, 0, 0, 0, 0);
        add(0, 0, 1, 3'b000, 0,  3, 0, 0, 0, 0, 0);
        add(0, 0, 1, 3'b000, 0,  3, 0, 0, 1, 0, 0);
        add(0, 1, 1, 3'b000, 0,  3, 0, 0, 1, 0, 0);
        add(0, 0, 1, 3'b011, 1,  3, 1, 0, 0, 0, 1);
        add(0, 0, 1, 3'b000, 0,  3, 1, 0, 1, 0, 1);
        add(0, 1, 1, 3'b000, 0,  3, 1, 0, 1, 0, 1);
        add(0, 1, 0, 3'b000, 0,  3, 1, 0, 0, 0, 1);
        add(0, 1, 0, 3'b000, 0,  3, 1, 0, 0, 0, 1);
        add(0, 1, 0, 3'b001, 0,  3, 0, 0, 0, 0, 1);
        add(0, 1, 0, 3'b000, 1,  2, 0, 1, 0, 0, 1);
        add(0, 0, 0, 3'b000, 0,  2, 0, 0, 0, 0, 1);
        add(0, 1, 0, 3'b000, 0,  1, 0, 1, 0, 0, 1);
        add(0, 1, 1, 3'b000, 0,  0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 3'b001, 0,  0, 0, 0, 0, 1, 0);
        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].r, tv[i].t, tv[i].c, tv[i].s, tv[i].x);
            chk($sformatf("vec%0d.credit", i), int'(credit), tv[i].cr);
            chk($sformatf("vec%0d.motor", i), int'(motor), tv[i].mo);
            chk($sformatf("vec%0d.change_out", i), int'(change_out), int'(tv[i].ch));
            chk($sformatf("vec%0d.coin_reject", i), int'(coin_reject), int'(tv[i].rj));
            chk($sformatf("vec%0d.sel_err", i), int'(sel_err), int'(tv[i].er));
            chk($sformatf("vec%0d.busy", i), int'(busy), int'(tv[i].bz));
        end
        // credit 2 with sel 011, coin and cancel together: drink 1 wins, credit 2-1+1
        step(1, 0, 0, 3'b000, 0);
        step(0, 0, 1, 3'b000, 0);
        step(0, 0, 1, 3'b000, 0);
        step(0, 0, 1, 3'b011, 1);
        chk("mix.credit", int'(credit), 2);
        chk("mix.motor", int'(motor), 1);
        chk("mix.busy", int'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 3'b000, 0);
            chk("mix.no_refund_yet", int'(change_out), 0);
        end
        step(0, 1, 0, 3'b000, 0);
        check_model("mix_end");
        chk("mix_end.motor_off", int'(motor), 0);
        chk("mix_end.refund_busy", int'(busy), 1);
        step(0, 1, 0, 3'b000, 0);
        check_model("mix_ref1");
        step(0, 1, 0, 3'b000, 0);
        check_model("mix_ref2");
        chk("mix_ref2.idle", int'(busy), 0);
        // reset in the middle of a dispense
        step(0, 0, 1, 3'b000, 0);
        step(0, 0, 1, 3'b000, 0);
        step(0, 0, 0, 3'b010, 0);
        step(0, 1, 0, 3'b000, 0);
        step(1, 1, 1, 3'b001, 1);
        chk("rst_mid.motor", int'(motor), 0);
        chk("rst_mid.credit", int'(credit), 0);
        chk("rst_mid.busy", int'(busy), 0);
        step(0, 1, 0, 3'b000, 0);
        chk("rst_mid.no_change", int'(change_out), 0);
        check_model("rst_mid");
        // three vends then reset clears the counter
        for (int v = 0; v < 3; v++) begin
            step(0, 0, 1, 3'b000, 0);
            step(0, 0, 0, 3'b001, 0);
            for (int k = 0; k < DT; k++) step(0, 1, 0, 3'b000, 0);
            check_model("vend");
        end
        chk("stats.count3", int'(vend_count), STATS ? 3 : 0);
        step(1, 0, 0, 3'b000, 0);
        chk("stats.cleared", int'(vend_count), 0);
        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit r, t, c, x;
            logic [2:0] s;
            r = $urandom_range(0, 199) == 0;
            t = $urandom_range(0, 2) == 0;
            s = $urandom_range(0, 3) == 0 ? 3'($urandom_range(1, 7)) : 3'b000;
            c = s == 3'b000 && $urandom_range(0, 2) == 0;
            x = !c && $urandom_range(0, 7) == 0;
            step(r, t, c, s, x);
            check_model("rnd");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
